// File: rtl/bp_ras_ctrl_pkg.sv
// Shared constants for the branch-predictor RAS controller: address width,
// prediction kind encoding, RISC-V opcode/funct3 values and the link-register test.
// Combinational helpers only; no state.
package bp_ras_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    BP_KIND_NONE = 2'd0,
    BP_KIND_CALL = 2'd1,
    BP_KIND_RET  = 2'd2,
    BP_KIND_JUMP = 2'd3
  } bp_kind_e;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [2:0] F3_JALR  = 3'b000;

  // x1 (ra) and x5 (t0) are the ABI link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/bp_ras_ctrl_decode.sv
// Instruction classifier for the RAS controller: call / return / jump / other.
// Purely combinational, zero latency.
// No handshake; the caller qualifies the push/pop hints with its own accept.
// Optional feature macro: BP_RAS_COROUTINE_EN (coroutine JALR swaps the RAS top).
module bp_ras_ctrl_decode
  import bp_ras_ctrl_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [31:0]           inst,
  output bp_kind_e              kind,
  output logic                  is_push,
  output logic                  is_pop,
  output logic                  known_jump,
  output logic [ADDR_WIDTH-1:0] jal_target
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [20:0] j_imm;
  logic        rd_link;
  logic        rs1_link;

  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1      = inst[19:15];
  assign j_imm    = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  // JAL target wraps modulo the address space.
  assign jal_target = pc + {{(ADDR_WIDTH-21){j_imm[20]}}, j_imm};

  // Classify the instruction and derive its RAS action.
  always_comb begin
    kind       = BP_KIND_NONE;
    is_push    = 1'b0;
    is_pop     = 1'b0;
    known_jump = 1'b0;
    if (opcode == OPC_JAL) begin
      known_jump = 1'b1;
      if (rd_link) begin
        kind    = BP_KIND_CALL;
        is_push = 1'b1;
      end else begin
        kind = BP_KIND_JUMP;
      end
    end else if (opcode == OPC_JALR && funct3 == F3_JALR) begin
      if (!rd_link && !rs1_link) begin
        // Indirect jump: target comes from a register we cannot see.
        kind = BP_KIND_JUMP;
      end else if (rd_link && !rs1_link) begin
        kind    = BP_KIND_CALL;
        is_push = 1'b1;
      end else if (!rd_link && rs1_link) begin
        kind       = BP_KIND_RET;
        is_pop     = 1'b1;
        known_jump = 1'b1;
      end else if (rd == rs1) begin
        kind    = BP_KIND_CALL;
        is_push = 1'b1;
      end else begin
`ifdef BP_RAS_COROUTINE_EN
        // Coroutine swap: return to the top, then push our own link.
        kind       = BP_KIND_RET;
        is_push    = 1'b1;
        is_pop     = 1'b1;
        known_jump = 1'b1;
`else
        kind    = BP_KIND_CALL;
        is_push = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/bp_ras_ctrl.sv
// RAS controller: decodes accepted fetch instructions, strobes the RAS, registers a prediction.
// Latency: prediction valid one cycle after accept; RAS strobes are same-cycle combinational.
// Backpressure: one-entry output stage; fetch ready only when the stage is empty or being drained.
// Optional feature macro: BP_RAS_COROUTINE_EN.
module bp_ras_ctrl
  import bp_ras_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fetch_bp_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_bp_pc,
  input  logic [31:0]           fetch_bp_inst,
  output logic                  bp_fetch_ready,
  output logic                  bp_decode_valid,
  output logic [ADDR_WIDTH-1:0] bp_decode_pc,
  output logic                  bp_decode_jump,
  output logic [ADDR_WIDTH-1:0] bp_decode_target,
  output logic [1:0]            bp_decode_kind,
  input  logic                  decode_bp_ready,
  output logic [ADDR_WIDTH-1:0] bp_ras_addr,
  output logic                  bp_ras_push,
  output logic                  bp_ras_pop,
  input  logic [ADDR_WIDTH-1:0] ras_bp_addr,
  output logic                  bp_csrf_call_add,
  output logic                  bp_csrf_ret_add
);

  bp_kind_e              dec_kind;
  logic                  dec_push;
  logic                  dec_pop;
  logic                  dec_known;
  logic [ADDR_WIDTH-1:0] dec_jal_target;
  logic [ADDR_WIDTH-1:0] next_target;
  logic                  accept;

  bp_ras_ctrl_decode u_decode (
    .pc         (fetch_bp_pc),
    .inst       (fetch_bp_inst),
    .kind       (dec_kind),
    .is_push    (dec_push),
    .is_pop     (dec_pop),
    .known_jump (dec_known),
    .jal_target (dec_jal_target)
  );

  assign bp_fetch_ready = !flush && (!bp_decode_valid || decode_bp_ready);
  assign accept         = fetch_bp_valid && bp_fetch_ready;

  // Strobes only on accept so a stalled offer never touches the RAS twice.
  assign bp_ras_push = accept && dec_push;
  assign bp_ras_pop  = accept && dec_pop;
  assign bp_ras_addr = fetch_bp_pc + ADDR_WIDTH'(4);

  // Returns take the pre-pop RAS top; everything else known uses the JAL adder.
  assign next_target = !dec_known ? '0 : (dec_pop ? ras_bp_addr : dec_jal_target);

  // Output stage: flush drops it, accept (re)loads it, a consume without accept empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_decode_valid  <= 1'b0;
      bp_decode_pc     <= '0;
      bp_decode_jump   <= 1'b0;
      bp_decode_target <= '0;
      bp_decode_kind   <= BP_KIND_NONE;
    end else if (flush) begin
      bp_decode_valid <= 1'b0;
    end else if (accept) begin
      bp_decode_valid  <= 1'b1;
      bp_decode_pc     <= fetch_bp_pc;
      bp_decode_jump   <= dec_known;
      bp_decode_target <= next_target;
      bp_decode_kind   <= dec_kind;
    end else if (decode_bp_ready) begin
      bp_decode_valid <= 1'b0;
    end
  end

  // Performance-counter pulses follow the RAS strobes; flush does not cancel them.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_csrf_call_add <= 1'b0;
      bp_csrf_ret_add  <= 1'b0;
    end else begin
      bp_csrf_call_add <= bp_ras_push;
      bp_csrf_ret_add  <= bp_ras_pop;
    end
  end

endmodule

// File: tb/tb_bp_ras_ctrl.sv
// Directed bench for bp_ras_ctrl with a prediction scoreboard and a RAS model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_bp_ras_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fetch_bp_valid;
  logic [31:0] fetch_bp_pc;
  logic [31:0] fetch_bp_inst;
  logic        bp_fetch_ready;
  logic        bp_decode_valid;
  logic [31:0] bp_decode_pc;
  logic        bp_decode_jump;
  logic [31:0] bp_decode_target;
  logic [1:0]  bp_decode_kind;
  logic        decode_bp_ready;
  logic [31:0] bp_ras_addr;
  logic        bp_ras_push;
  logic        bp_ras_pop;
  logic [31:0] ras_bp_addr;
  logic        bp_csrf_call_add;
  logic        bp_csrf_ret_add;

  bp_ras_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .fetch_bp_valid   (fetch_bp_valid),
    .fetch_bp_pc      (fetch_bp_pc),
    .fetch_bp_inst    (fetch_bp_inst),
    .bp_fetch_ready   (bp_fetch_ready),
    .bp_decode_valid  (bp_decode_valid),
    .bp_decode_pc     (bp_decode_pc),
    .bp_decode_jump   (bp_decode_jump),
    .bp_decode_target (bp_decode_target),
    .bp_decode_kind   (bp_decode_kind),
    .decode_bp_ready  (decode_bp_ready),
    .bp_ras_addr      (bp_ras_addr),
    .bp_ras_push      (bp_ras_push),
    .bp_ras_pop       (bp_ras_pop),
    .ras_bp_addr      (ras_bp_addr),
    .bp_csrf_call_add (bp_csrf_call_add),
    .bp_csrf_ret_add  (bp_csrf_ret_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic [31:0] tgt;
    logic [1:0]  kind;
  } pred_t;

  pred_t       sb[$];
  logic [31:0] ras_m[$];
  logic        call_q;
  logic        ret_q;
  int          vectors;
  int          miscompares;

  localparam logic [31:0] ADD_X3 = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

`ifdef BP_RAS_COROUTINE_EN
  localparam logic [1:0] CO_KIND = 2'd2;
  localparam logic       CO_JUMP = 1'b1;
  localparam logic       CO_RAS  = 1'b1;
  localparam logic       CO_POP  = 1'b1;
`else
  localparam logic [1:0] CO_KIND = 2'd1;
  localparam logic       CO_JUMP = 1'b0;
  localparam logic       CO_RAS  = 1'b0;
  localparam logic       CO_POP  = 1'b0;
`endif

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [2:0] f3);
    return {12'h000, rs1, f3, rd, 7'b1100111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational and registered outputs, update models, clock.
  task automatic cyc(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic dr, input logic fl, input logic [1:0] kind, input logic jump,
                     input logic [31:0] tgt, input logic use_ras, input logic ep, input logic eo);
    logic  exp_rdy;
    logic  acc;
    pred_t p;
    fetch_bp_valid  = v;
    fetch_bp_pc     = pc;
    fetch_bp_inst   = inst;
    decode_bp_ready = dr;
    flush           = fl;
    ras_bp_addr     = (ras_m.size() != 0) ? ras_m[$] : 32'h0;
    #1;
    exp_rdy = !fl && (sb.size() == 0 || dr);
    acc     = v && exp_rdy;
    chk({tag, ":ready"}, 32'(bp_fetch_ready), 32'(exp_rdy));
    chk({tag, ":push"}, 32'(bp_ras_push), 32'(acc && ep));
    chk({tag, ":pop"}, 32'(bp_ras_pop), 32'(acc && eo));
    if (acc && ep) chk({tag, ":ras_addr"}, bp_ras_addr, pc + 32'd4);
    chk({tag, ":valid"}, 32'(bp_decode_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, ":pc"}, bp_decode_pc, sb[0].pc);
      chk({tag, ":jump"}, 32'(bp_decode_jump), 32'(sb[0].jump));
      chk({tag, ":target"}, bp_decode_target, sb[0].tgt);
      chk({tag, ":kind"}, 32'(bp_decode_kind), 32'(sb[0].kind));
    end
    chk({tag, ":call_add"}, 32'(bp_csrf_call_add), 32'(call_q));
    chk({tag, ":ret_add"}, 32'(bp_csrf_ret_add), 32'(ret_q));
    if (sb.size() != 0 && (dr || fl)) void'(sb.pop_front());
    if (acc) begin
      p.pc   = pc;
      p.jump = jump;
      p.tgt  = use_ras ? ras_bp_addr : tgt;
      p.kind = kind;
      sb.push_back(p);
    end
    call_q = acc && ep;
    ret_q  = acc && eo;
    if (acc && eo && ras_m.size() != 0) void'(ras_m.pop_back());
    if (acc && ep) ras_m.push_back(pc + 32'd4);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst             = 1'b1;
    fetch_bp_valid  = 1'b0;
    fetch_bp_pc     = 32'h0;
    fetch_bp_inst   = 32'h0;
    flush           = 1'b0;
    decode_bp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    call_q = 1'b0;
    ret_q  = 1'b0;
    chk({tag, ":valid"}, 32'(bp_decode_valid), 32'h0);
    chk({tag, ":pc"}, bp_decode_pc, 32'h0);
    chk({tag, ":jump"}, 32'(bp_decode_jump), 32'h0);
    chk({tag, ":target"}, bp_decode_target, 32'h0);
    chk({tag, ":kind"}, 32'(bp_decode_kind), 32'h0);
    chk({tag, ":call_add"}, 32'(bp_csrf_call_add), 32'h0);
    chk({tag, ":ret_add"}, 32'(bp_csrf_ret_add), 32'h0);
    chk({tag, ":ready"}, 32'(bp_fetch_ready), 32'h1);
    chk({tag, ":push"}, 32'(bp_ras_push), 32'h0);
    chk({tag, ":pop"}, 32'(bp_ras_pop), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors         = 0;
    miscompares     = 0;
    call_q          = 1'b0;
    ret_q           = 1'b0;
    ras_bp_addr     = 32'h0;
    rst             = 1'b1;
    flush           = 1'b0;
    fetch_bp_valid  = 1'b0;
    fetch_bp_pc     = 32'h0;
    fetch_bp_inst   = 32'h0;
    decode_bp_ready = 1'b0;
    @(posedge clk);
    do_reset("reset");

    // Call then return, plus basic classes.
    cyc("call", 1, 32'h1000, enc_jal(5'd1, 21'h100), 1, 0, 2'd1, 1, 32'h1100, 0, 1, 0);
    cyc("ret", 1, 32'h1100, enc_jalr(5'd0, 5'd1, 3'b000), 1, 0, 2'd2, 1, 32'h1004, 1, 0, 1);
    cyc("add", 1, 32'h1104, ADD_X3, 1, 0, 2'd0, 0, 32'h0, 0, 0, 0);
    cyc("jal_neg", 1, 32'h2000, enc_jal(5'd0, 21'h1FFFF8), 1, 0, 2'd3, 1, 32'h1FF8, 0, 0, 0);
    cyc("jalr_plain", 1, 32'h2004, enc_jalr(5'd0, 5'd2, 3'b000), 1, 0, 2'd3, 0, 32'h0, 0, 0, 0);
    cyc("jalr_call", 1, 32'h2008, enc_jalr(5'd1, 5'd2, 3'b000), 1, 0, 2'd1, 0, 32'h0, 0, 1, 0);
    cyc("jalr_x5x5", 1, 32'h200C, enc_jalr(5'd5, 5'd5, 3'b000), 1, 0, 2'd1, 0, 32'h0, 0, 1, 0);
    cyc("ret_a", 1, 32'h2010, enc_jalr(5'd0, 5'd5, 3'b000), 1, 0, 2'd2, 1, 32'h2010, 1, 0, 1);
    cyc("ret_b", 1, 32'h2014, enc_jalr(5'd0, 5'd1, 3'b000), 1, 0, 2'd2, 1, 32'h200C, 1, 0, 1);
    cyc("f3_none", 1, 32'h2018, enc_jalr(5'd0, 5'd1, 3'b001), 1, 0, 2'd0, 0, 32'h0, 0, 0, 0);
    idle("drain0");

    // Backpressure: one accept, then held offer must not strobe again.
    for (int i = 0; i < 4; i++)
      cyc("bp_hold", 1, 32'h3000, enc_jal(5'd1, 21'h40), 0, 0, 2'd1, 1, 32'h3040, 0, 1, 0);
    idle("bp_consume");
    idle("bp_drain");

    // Flush during a held call.
    cyc("fl_acc", 1, 32'h4000, enc_jal(5'd1, 21'h20), 0, 0, 2'd1, 1, 32'h4020, 0, 1, 0);
    cyc("fl_hold", 1, 32'h4000, enc_jal(5'd1, 21'h20), 0, 1, 2'd1, 1, 32'h4020, 0, 1, 0);
    cyc("fl_after", 1, 32'h4010, enc_jal(5'd1, 21'h20), 1, 0, 2'd1, 1, 32'h4030, 0, 1, 0);
    idle("fl_drain");

    // Coroutine JALR x5,0(x1).
    cyc("coro", 1, 32'h5000, enc_jalr(5'd5, 5'd1, 3'b000), 1, 0, CO_KIND, CO_JUMP, 32'h0, CO_RAS, 1, CO_POP);
    idle("coro_drain");

    // Push address and JAL target wrap at the top of the address space.
    cyc("wrap", 1, 32'hFFFFFFFC, enc_jal(5'd1, 21'h100), 1, 0, 2'd1, 1, 32'h000000FC, 0, 1, 0);
    idle("wrap_drain");

    // Reset with a prediction held and a pulse in flight.
    cyc("rst_acc", 1, 32'h6000, enc_jal(5'd1, 21'h10), 0, 0, 2'd1, 1, 32'h6010, 0, 1, 0);
    cyc("rst_hold", 0, 32'h0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 0, 0, 0);
    do_reset("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
